// File: rtl/msg_ram_pkg.sv
// -----------------------------------------------------------------------------
// msg_ram_pkg
// Shared constants and types for the message RAM controller slice.
//   MSG_WIDTH  : width of one message word
//   MEM_HEIGHT : depth of the message RAM in words
//   ADDR       : RAM address width, clog2(MEM_HEIGHT)
//   STALL_W    : width of the saturating producer-stall counter
//   msg_t / addr_t / cnt_t : message, address and occupancy types
//   grant_e    : identifies which producer won the last accepted write
// -----------------------------------------------------------------------------
package msg_ram_pkg;

    localparam int MSG_WIDTH  = 8;
    localparam int MEM_HEIGHT = 8;
    localparam int ADDR       = $clog2(MEM_HEIGHT);
    localparam int STALL_W    = 16;

    typedef logic [MSG_WIDTH-1:0] msg_t;
    typedef logic [ADDR-1:0]      addr_t;
    typedef logic [ADDR:0]        cnt_t;

    typedef enum logic {
        GRANT_S0 = 1'b0,
        GRANT_S1 = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. Grants are combinational from the
// registered last_grant; last_grant only moves when a grant is accepted.
//   clk, rst     : clock, synchronous active-high reset
//   req0, req1   : requests from producer 0 / producer 1
//   block        : suppresses all grants (buffer full)
//   accept       : the current grant was consumed this cycle
//   gnt0, gnt1   : one-hot grant (or none)
// -----------------------------------------------------------------------------
module rr_arb2
    import msg_ram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic block,
    input  logic accept,
    output logic gnt0,
    output logic gnt1
);

    grant_e last_grant;

    // Grant decode: a lone requester always wins; on contention the
    // requester that did not win last time gets the slot.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!block) begin
            if (req0 && req1) begin
                if (last_grant == GRANT_S1) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Reset to GRANT_S1 so producer 0 wins the very first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_S1;
        end else if (accept && (gnt0 || gnt1)) begin
            last_grant <= gnt1 ? GRANT_S1 : GRANT_S0;
        end
    end

endmodule

// File: rtl/msg_ram_ctrl.sv
// -----------------------------------------------------------------------------
// msg_ram_ctrl
// Runs one MEM_HEIGHT-deep message RAM as a circular FIFO shared by two
// producers (round-robin, one write per cycle) and one consumer.
//   clk, rst                 : clock, synchronous active-high reset
//   s0_valid/s0_data/s0_ready: producer 0 handshake (ready = accepted now)
//   s1_valid/s1_data/s1_ready: producer 1 handshake
//   rd_req                   : consumer pops the next message
//   rd_valid/rd_data         : popped message, one cycle after the pop
//   rd_underflow             : registered pulse for a pop while empty
//   ram_we/waddr/wdata       : RAM write port
//   ram_re/raddr/rdata       : RAM read port, rdata valid 1 clk after re
//   count/full/empty         : registered occupancy and its decodes
//   stall_cnt                : saturating count of full-blocked cycles
// -----------------------------------------------------------------------------
module msg_ram_ctrl #(
    parameter int MSG_WIDTH  = msg_ram_pkg::MSG_WIDTH,
    parameter int MEM_HEIGHT = msg_ram_pkg::MEM_HEIGHT,
    parameter int ADDR       = msg_ram_pkg::ADDR,
    parameter int STALL_W    = msg_ram_pkg::STALL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s0_valid,
    input  logic [MSG_WIDTH-1:0] s0_data,
    output logic                 s0_ready,
    input  logic                 s1_valid,
    input  logic [MSG_WIDTH-1:0] s1_data,
    output logic                 s1_ready,
    input  logic                 rd_req,
    output logic                 rd_valid,
    output logic [MSG_WIDTH-1:0] rd_data,
    output logic                 rd_underflow,
    output logic                 ram_we,
    output logic [ADDR-1:0]      ram_waddr,
    output logic [MSG_WIDTH-1:0] ram_wdata,
    output logic                 ram_re,
    output logic [ADDR-1:0]      ram_raddr,
    input  logic [MSG_WIDTH-1:0] ram_rdata,
    output logic [ADDR:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic [STALL_W-1:0]   stall_cnt
);

    localparam logic [ADDR:0]   FULL_COUNT = (ADDR+1)'(MEM_HEIGHT);
    localparam logic [ADDR-1:0] LAST_ADDR  = ADDR'(MEM_HEIGHT-1);

    logic [ADDR-1:0] wr_ptr;
    logic [ADDR-1:0] rd_ptr;
    logic            gnt0;
    logic            gnt1;
    logic            wr_en;
    logic            rd_en;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (s0_valid),
        .req1   (s1_valid),
        .block  (full),
        .accept (wr_en),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    // A grant is an accepted write; a pop needs at least one stored word.
    // Both use start-of-cycle state, so at full a pop wins and the write
    // waits one cycle, and at empty the write lands but the pop underflows.
    assign wr_en    = gnt0 | gnt1;
    assign rd_en    = rd_req & ~empty;
    assign s0_ready = gnt0;
    assign s1_ready = gnt1;

    assign ram_we    = wr_en;
    assign ram_waddr = wr_ptr;
    assign ram_re    = rd_en;
    assign ram_raddr = rd_ptr;
    assign rd_data   = ram_rdata;

    // Write data mux; idle cycles drive zero rather than stale data.
    always_comb begin
        ram_wdata = '0;
        if (gnt0) begin
            ram_wdata = s0_data;
        end else if (gnt1) begin
            ram_wdata = s1_data;
        end
    end

    // Pointers, occupancy, read-valid pipeline and stall counter.
    // rd_valid mirrors the RAM's one-cycle read latency; reset drops any
    // read issued in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_valid     <= 1'b0;
            rd_underflow <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            rd_valid     <= rd_en;
            rd_underflow <= rd_req & empty;
            if ((s0_valid || s1_valid) && full && (stall_cnt != {STALL_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_msg_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_msg_ram_ctrl
// Directed bench for msg_ram_ctrl with a behavioural RAM attached to the
// RAM port. A vector table covers fill/full/drain/underflow; hand-written
// sequences cover contention, pointer wrap with simultaneous push/pop,
// full-with-pop priority and reset during a read.
// -----------------------------------------------------------------------------
module tb_msg_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s1_valid, rd_req;
    logic [7:0]  s0_data, s1_data;
    logic        s0_ready, s1_ready;
    logic        rd_valid, rd_underflow;
    logic [7:0]  rd_data;
    logic        ram_we, ram_re;
    logic [2:0]  ram_waddr, ram_raddr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic [3:0]  count;
    logic        full, empty;
    logic [15:0] stall_cnt;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    msg_ram_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .s0_valid     (s0_valid),
        .s0_data      (s0_data),
        .s0_ready     (s0_ready),
        .s1_valid     (s1_valid),
        .s1_data      (s1_data),
        .s1_ready     (s1_ready),
        .rd_req       (rd_req),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_underflow (rd_underflow),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata),
        .ram_re       (ram_re),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .stall_cnt    (stall_cnt)
    );

    // Behavioural synchronous RAM with one-cycle read latency.
    logic [7:0] mem [8];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    typedef struct {
        logic        s0v;
        logic [7:0]  s0d;
        logic        rdq;
        logic        e_s0r;
        logic        e_we;
        logic [2:0]  e_waddr;
        logic [7:0]  e_wdata;
        logic        e_re;
        logic [2:0]  e_raddr;
        logic [3:0]  e_count;
        logic        e_rdv;
        logic [7:0]  e_rdd;
        logic        e_unf;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vecs [21];

    // Reference model state for the modelled sequences.
    int         m_w, m_r, m_c, m_stall;
    logic       pend_v, pend_u;
    logic [7:0] pend_d;
    logic [7:0] q [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                 input logic v1, input logic [7:0] d1,
                                 input logic rq);
        @(negedge clk);
        rst      = 1'b0;
        s0_valid = v0;
        s0_data  = d0;
        s1_valid = v1;
        s1_data  = d1;
        rd_req   = rq;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        s0_data  = 8'h00;
        s1_data  = 8'h00;
        rd_req   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic modelReset();
        m_w = 0; m_r = 0; m_c = 0; m_stall = 0;
        pend_v = 1'b0; pend_u = 1'b0; pend_d = 8'h00;
        q.delete();
    endtask

    // One cycle of producer-0 / consumer traffic checked against the model.
    task automatic modelStep(input logic v, input logic [7:0] d, input logic rq);
        logic acc, rd;
        acc = v && (m_c < 8);
        rd  = rq && (m_c > 0);
        applyStimulus(v, d, 1'b0, 8'h00, rq);
        checkOutput("m_s0_ready", s0_ready, acc);
        checkOutput("m_s1_ready", s1_ready, 0);
        checkOutput("m_ram_we", ram_we, acc);
        checkOutput("m_ram_waddr", ram_waddr, m_w);
        if (acc) checkOutput("m_ram_wdata", ram_wdata, d);
        checkOutput("m_ram_re", ram_re, rd);
        checkOutput("m_ram_raddr", ram_raddr, m_r);
        checkOutput("m_count", count, m_c);
        checkOutput("m_full", full, m_c == 8);
        checkOutput("m_empty", empty, m_c == 0);
        checkOutput("m_rd_valid", rd_valid, pend_v);
        if (pend_v) checkOutput("m_rd_data", rd_data, pend_d);
        checkOutput("m_rd_underflow", rd_underflow, pend_u);
        checkOutput("m_stall_cnt", stall_cnt, m_stall);
        if (v && m_c == 8) m_stall++;
        pend_u = rq && (m_c == 0);
        pend_v = rd;
        if (rd) begin
            pend_d = q.pop_front();
            m_r = (m_r + 1) % 8;
        end
        if (acc) begin
            q.push_back(d);
            m_w = (m_w + 1) % 8;
        end
        m_c = m_c + int'(acc) - int'(rd);
    endtask

    initial begin
        logic [7:0] order [4];
        int ai, bi;
        logic exp0;
        logic [7:0] exp_d;

        rst = 1'b1;
        s0_valid = 1'b0; s1_valid = 1'b0; rd_req = 1'b0;
        s0_data = 8'h00; s1_data = 8'h00;

        // ---- table: reset state, fill 0x10..0x17, full stall, drain, underflow
        vecs[0] = '{s0v:0, s0d:8'h00, rdq:0, e_s0r:0, e_we:0, e_waddr:0, e_wdata:8'h00,
                    e_re:0, e_raddr:0, e_count:0, e_rdv:0, e_rdd:8'h00, e_unf:0, e_stall:0};
        for (int i = 0; i < 8; i++) begin
            vecs[1+i] = '{s0v:1, s0d:8'(8'h10 + i), rdq:0, e_s0r:1, e_we:1, e_waddr:3'(i),
                          e_wdata:8'(8'h10 + i), e_re:0, e_raddr:0, e_count:4'(i),
                          e_rdv:0, e_rdd:8'h00, e_unf:0, e_stall:0};
        end
        vecs[9]  = '{s0v:1, s0d:8'h18, rdq:0, e_s0r:0, e_we:0, e_waddr:0, e_wdata:8'h00,
                     e_re:0, e_raddr:0, e_count:8, e_rdv:0, e_rdd:8'h00, e_unf:0, e_stall:0};
        vecs[10] = '{s0v:0, s0d:8'h00, rdq:0, e_s0r:0, e_we:0, e_waddr:0, e_wdata:8'h00,
                     e_re:0, e_raddr:0, e_count:8, e_rdv:0, e_rdd:8'h00, e_unf:0, e_stall:1};
        for (int j = 0; j < 8; j++) begin
            vecs[11+j] = '{s0v:0, s0d:8'h00, rdq:1, e_s0r:0, e_we:0, e_waddr:0, e_wdata:8'h00,
                           e_re:1, e_raddr:3'(j), e_count:4'(8 - j), e_rdv:(j > 0),
                           e_rdd:8'(8'h10 + j - 1), e_unf:0, e_stall:1};
        end
        vecs[19] = '{s0v:0, s0d:8'h00, rdq:1, e_s0r:0, e_we:0, e_waddr:0, e_wdata:8'h00,
                     e_re:0, e_raddr:0, e_count:0, e_rdv:1, e_rdd:8'h17, e_unf:0, e_stall:1};
        vecs[20] = '{s0v:0, s0d:8'h00, rdq:0, e_s0r:0, e_we:0, e_waddr:0, e_wdata:8'h00,
                     e_re:0, e_raddr:0, e_count:0, e_rdv:0, e_rdd:8'h00, e_unf:1, e_stall:1};

        doReset();
        for (int r = 0; r < 21; r++) begin
            applyStimulus(vecs[r].s0v, vecs[r].s0d, 1'b0, 8'h00, vecs[r].rdq);
            checkOutput($sformatf("v%0d_s0_ready", r), s0_ready, vecs[r].e_s0r);
            checkOutput($sformatf("v%0d_s1_ready", r), s1_ready, 0);
            checkOutput($sformatf("v%0d_ram_we", r), ram_we, vecs[r].e_we);
            checkOutput($sformatf("v%0d_ram_waddr", r), ram_waddr, vecs[r].e_waddr);
            checkOutput($sformatf("v%0d_ram_wdata", r), ram_wdata, vecs[r].e_wdata);
            checkOutput($sformatf("v%0d_ram_re", r), ram_re, vecs[r].e_re);
            checkOutput($sformatf("v%0d_ram_raddr", r), ram_raddr, vecs[r].e_raddr);
            checkOutput($sformatf("v%0d_count", r), count, vecs[r].e_count);
            checkOutput($sformatf("v%0d_full", r), full, vecs[r].e_count == 4'd8);
            checkOutput($sformatf("v%0d_empty", r), empty, vecs[r].e_count == 4'd0);
            checkOutput($sformatf("v%0d_rd_valid", r), rd_valid, vecs[r].e_rdv);
            if (vecs[r].e_rdv) checkOutput($sformatf("v%0d_rd_data", r), rd_data, vecs[r].e_rdd);
            checkOutput($sformatf("v%0d_rd_underflow", r), rd_underflow, vecs[r].e_unf);
            checkOutput($sformatf("v%0d_stall_cnt", r), stall_cnt, vecs[r].e_stall);
        end

        // ---- contention: grants alternate s0,s1,s0,s1 starting with s0
        order[0] = 8'hA0; order[1] = 8'hB0; order[2] = 8'hA1; order[3] = 8'hB1;
        doReset();
        ai = 0; bi = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 8'(8'hA0 + ai), 1'b1, 8'(8'hB0 + bi), 1'b0);
            exp0 = (k % 2 == 0);
            checkOutput($sformatf("arb%0d_s0_ready", k), s0_ready, exp0);
            checkOutput($sformatf("arb%0d_s1_ready", k), s1_ready, !exp0);
            checkOutput($sformatf("arb%0d_ram_waddr", k), ram_waddr, k);
            checkOutput($sformatf("arb%0d_ram_wdata", k), ram_wdata, order[k]);
            if (exp0) ai++; else bi++;
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, k < 4);
            if (k == 0) checkOutput("arb_count", count, 4);
            checkOutput($sformatf("arb_drain%0d_rd_valid", k), rd_valid, k > 0);
            if (k > 0) begin
                exp_d = order[k-1];
                checkOutput($sformatf("arb_drain%0d_rd_data", k), rd_data, exp_d);
            end
        end

        // ---- wrap: fill to 5, then 12 cycles of push+pop, then full priority
        doReset();
        modelReset();
        for (int i = 0; i < 5; i++) modelStep(1'b1, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 12; i++) modelStep(1'b1, 8'(8'h60 + i), 1'b1);
        for (int i = 0; i < 3; i++) modelStep(1'b1, 8'(8'h70 + i), 1'b0);
        modelStep(1'b1, 8'h80, 1'b1);
        modelStep(1'b1, 8'h80, 1'b0);
        modelStep(1'b0, 8'h00, 1'b1);
        modelStep(1'b0, 8'h00, 1'b1);

        // ---- reset in the middle of a read
        @(negedge clk);
        rst = 1'b1; rd_req = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0;
        #1;
        checkOutput("rst_cycle_ram_re", ram_re, 1);
        @(negedge clk);
        rst = 1'b0; rd_req = 1'b0;
        #1;
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        modelReset();
        modelStep(1'b1, 8'hEE, 1'b0);
        modelStep(1'b0, 8'h00, 1'b1);
        modelStep(1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/msg_ram_ctrl.md
Name: msg_ram_ctrl

Overview:
- Controller that shares one MEM_HEIGHT-deep message RAM between two message producers and one consumer.
- Operates the RAM as a circular FIFO.
- Round-robin arbitration between the two producers, one write per cycle.
- Tracks write/read pointers and occupancy, issues RAM reads for the consumer, and counts producer stalls caused by a full buffer.

Parameters:
- MSG_WIDTH, 8, message/data width in bits
- MEM_HEIGHT, 8, RAM depth in words; must equal 2**ADDR
- ADDR, 3, RAM address width
- STALL_W, 16, width of the saturating stall counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- s0_valid  input  1  producer 0 has a message
- s0_data  input  MSG_WIDTH  producer 0 message
- s0_ready  output  1  producer 0 message accepted this cycle
- s1_valid  input  1  producer 1 has a message
- s1_data  input  MSG_WIDTH  producer 1 message
- s1_ready  output  1  producer 1 message accepted this cycle
- rd_req  input  1  consumer requests the next message
- rd_valid  output  1  rd_data holds a popped message
- rd_data  output  MSG_WIDTH  popped message (pass-through of ram_rdata)
- rd_underflow  output  1  pulse: rd_req while empty
- ram_we  output  1  RAM write enable
- ram_waddr  output  ADDR  RAM write address
- ram_wdata  output  MSG_WIDTH  RAM write data
- ram_re  output  1  RAM read enable
- ram_raddr  output  ADDR  RAM read address
- ram_rdata  input  MSG_WIDTH  RAM read data, valid 1 clk after ram_re
- count  output  ADDR+1  current occupancy, 0..MEM_HEIGHT
- full  output  1  count == MEM_HEIGHT
- empty  output  1  count == 0
- stall_cnt  output  STALL_W  cycles with a producer valid but blocked by full

Behaviour:
- **Reset** (rst=1 at rising edge):
  - wr_ptr, rd_ptr, count cleared to 0; rd_valid=0, rd_underflow=0, stall_cnt=0.
  - last_grant=1, so producer 0 wins the first contention.
  - RAM contents are not cleared.
  - Reset mid-operation discards any in-flight read: rd_valid is 0 in the cycle after reset.
- **Status flags:** full and empty decode the registered count, so they reflect start-of-cycle state only.
- **Arbitration** (combinational from registered state):
  - If full, no grant.
  - If only one producer is valid, grant it.
  - If both are valid, grant the one not equal to last_grant.
  - sN_ready=1 only for the granted producer; ready is never asserted without the matching valid.
  - last_grant updates only on an accepted write.
- **Write on accept:**
  - Same cycle: ram_we=1, ram_waddr=wr_ptr, ram_wdata=granted data.
  - Next edge: wr_ptr <= wr_ptr+1, wrapping MEM_HEIGHT-1 -> 0.
  - When idle: ram_we=0, ram_waddr=wr_ptr, ram_wdata=0.
- **Read on rd_req & !empty:**
  - Same cycle: ram_re=1, ram_raddr=rd_ptr.
  - Next edge: rd_ptr <= rd_ptr+1 with wrap.
  - rd_valid is a registered 1-cycle pulse in the following cycle; rd_data=ram_rdata is meaningful only while rd_valid=1.
  - Back-to-back rd_req sustains one message per cycle.
- **Underflow:** rd_req & empty gives no RAM read, no pointer change, and rd_underflow=1 registered the next cycle.
- **Occupancy update:**
  - Write accepted and no read: count+1.
  - Read and no write: count-1.
  - Both or neither: unchanged.
- **Simultaneous events:**
  - Empty + rd_req + producer valid: the write is accepted and the read is rejected with underflow. The written data is not bypassed.
  - Full + rd_req + producer valid: the read is accepted and the write is refused that cycle; the producer is accepted the next cycle.
  - Read and write at the same address in one cycle cannot occur: a read needs count>=1 and a write needs count<MEM_HEIGHT, and with read accepted, count < MEM_HEIGHT implies wr_ptr != rd_ptr.
- **stall_cnt:** increments by 1 each cycle (s0_valid|s1_valid) & full; saturates at all-ones.

Decomposition:
- Shared package msg_ram_pkg holds:
  - constants MSG_WIDTH, MEM_HEIGHT, ADDR (ADDR = clog2(MEM_HEIGHT));
  - typedef msg_t (MSG_WIDTH bits), addr_t (ADDR bits), cnt_t (ADDR+1 bits).
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter with last_grant state and a grant-accept input.
- Pointer, count and read pipeline stay in msg_ram_ctrl.

Test Plan:
- **Reset and idle:** after reset, count=0, empty=1, full=0, all readies 0, rd_valid=0, stall_cnt=0.
- **Single-producer fill:** s0_valid held with data 0x10..0x17 for 8 cycles gives ram_waddr 0..7 and count=8, full=1. A 9th valid gets s0_ready=0 and stall_cnt=1.
- **Drain:** rd_req held 8 cycles after the fill gives rd_valid pulses with rd_data 0x10..0x17 in order, each 1 clk after its ram_re. Ends with empty=1; a 9th rd_req gives rd_underflow=1.
- **Contention:** s0 and s1 valid continuously with s0=0xA0+i, s1=0xB0+i. Grants alternate s0,s1,s0,...; stored order 0xA0,0xB0,0xA1,0xB1.
- **Wrap and simultaneity:** fill to 5, then push+pop every cycle for 12 cycles. count stays 5, pointers wrap past 7 -> 0, and output order matches input. At full with valid+rd_req, the read is taken and the write is refused that cycle.
- **Reset mid-operation:** assert rst during a read cycle. rd_valid=0 next cycle, count=0; a subsequent write lands at address 0.
